// File: rtl/shift_engine_pkg.sv
// Shared types and constants for the framed serial shift engine.
package shift_engine_pkg;

    // Engine control state.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Bit-order encoding, matching the lsb_first input.
    localparam logic ORDER_MSB = 1'b0;
    localparam logic ORDER_LSB = 1'b1;

endpackage : shift_engine_pkg

// File: rtl/shift_bit_counter.sv
// Bit counter for one framed word: counts shift strobes and flags the last bit.
module shift_bit_counter
    import shift_engine_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    // Count strobes; clear has priority, and the count saturates at WIDTH-1.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Last bit of the word is being shifted when the count reaches WIDTH-1.
    always_comb begin
        last = (cnt == CNT_W'(WIDTH - 1));
    end

endmodule : shift_bit_counter

// File: rtl/shift_engine.sv
// Framed serial shift engine: loads a word on valid/ready, shifts it out
// MSB- or LSB-first on shift strobes while capturing serial_in, and returns
// the received word with a one-cycle rx_valid pulse.
// Optional feature macro: SHIFT_ENGINE_PARITY_EN adds the rx_parity output.
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             lsb_first,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
`ifdef SHIFT_ENGINE_PARITY_EN
    ,
    output logic             rx_parity
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           nextState;
    logic             loadFire;
    logic             shiftFire;
    logic             doneFire;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shiftNext;
    logic             order_q;
    logic [CNT_W-1:0] cnt;
    logic             cntLast;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: load leaves IDLE, the final strobe returns to it.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    nextState = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (shift_en && cntLast) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // State-decoded outputs and internal event strobes.
    always_comb begin
        tx_ready   = 1'b0;
        busy       = 1'b0;
        serial_out = 1'b0;
        loadFire   = 1'b0;
        shiftFire  = 1'b0;
        doneFire   = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_ready = 1'b1;
                loadFire = tx_valid;
            end
            ST_ACTIVE: begin
                busy       = 1'b1;
                serial_out = (order_q == ORDER_LSB) ? shreg[0] : shreg[WIDTH-1];
                shiftFire  = shift_en;
                doneFire   = shift_en && cntLast;
            end
            default: begin
                tx_ready = 1'b0;
            end
        endcase
    end

    // Shift register contents after the current strobe, in the latched bit order.
    always_comb begin
        if (order_q == ORDER_LSB) begin
            shiftNext = {serial_in, shreg[WIDTH-1:1]};
        end else begin
            shiftNext = {shreg[WIDTH-2:0], serial_in};
        end
    end

    // Shift register, bit order and received word; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            order_q  <= ORDER_MSB;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= doneFire;
            if (loadFire) begin
                shreg   <= tx_data;
                order_q <= lsb_first;
            end else if (shiftFire) begin
                shreg <= shiftNext;
            end
            if (doneFire) begin
                rx_data <= shiftNext;
            end
        end
    end

`ifdef SHIFT_ENGINE_PARITY_EN
    // Parity of the received word, captured alongside rx_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_parity <= 1'b0;
        end else if (doneFire) begin
            rx_parity <= ^shiftNext;
        end
    end
`endif

    // Bit counter; a load or a completed word restarts it from zero.
    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) bitCounter (
        .clk   (clk),
        .reset (reset),
        .clear (loadFire || doneFire),
        .inc   (shiftFire),
        .cnt   (cnt),
        .last  (cntLast)
    );

    // The counter is always parked at zero while idle.
    idleCountZero: assert property (@(posedge clk) disable iff (reset)
        (state == ST_IDLE) |-> (cnt == '0));

endmodule : shift_engine

// File: tb/tb_shift_engine.sv
// Directed bench for shift_engine with a word-level reference model.
module tb_shift_engine;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             shift_en = 1'b0;
    logic             lsb_first = 1'b0;
    logic [WIDTH-1:0] tx_data = '0;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic             serial_in;
    logic             serial_out;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;
`ifdef SHIFT_ENGINE_PARITY_EN
    logic             rx_parity;
`endif

    logic loopback = 1'b0;
    logic serialDrv = 1'b0;
    assign serial_in = loopback ? serial_out : serialDrv;

    shift_engine #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (shift_en),
        .lsb_first  (lsb_first),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_in  (serial_in),
        .serial_out (serial_out),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy)
`ifdef SHIFT_ENGINE_PARITY_EN
        ,
        .rx_parity  (rx_parity)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: a word is in flight, k strobes have been seen,
    // and received bit i lands at position i (LSB-first) or WIDTH-1-i (MSB-first).
    logic             mBusy = 1'b0;
    logic [WIDTH-1:0] mWord = '0;
    logic             mLsb = 1'b0;
    int               mK = 0;
    logic [WIDTH-1:0] mGot = '0;
    logic [WIDTH-1:0] mRxData = '0;
    logic             mRxValid = 1'b0;
    logic             mParity = 1'b0;

    // Inputs snapshotted mid-cycle, consumed by the model at the next edge.
    logic             sReset, sShift, sLsb, sValid, sSerial;
    logic [WIDTH-1:0] sData;
    logic             checkEn = 1'b0;

    always @(posedge clk) begin
        mRxValid = 1'b0;
        if (sReset) begin
            mBusy = 1'b0; mK = 0; mRxData = '0; mParity = 1'b0; mWord = '0;
        end else if (!mBusy) begin
            if (sValid) begin
                mBusy = 1'b1; mWord = sData; mLsb = sLsb; mK = 0; mGot = '0;
            end
        end else if (sShift) begin
            mGot[mLsb ? mK : WIDTH - 1 - mK] = sSerial;
            mK++;
            if (mK == WIDTH) begin
                mBusy = 1'b0; mK = 0; mRxData = mGot; mRxValid = 1'b1; mParity = ^mGot;
            end
        end
    end

    // Compare every cycle, then capture inputs for the model.
    always @(negedge clk) begin
        if (checkEn) begin
            chk("tx_ready", 32'(tx_ready), 32'(!mBusy));
            chk("busy", 32'(busy), 32'(mBusy));
            chk("serial_out", 32'(serial_out),
                32'(mBusy ? mWord[mLsb ? mK : WIDTH - 1 - mK] : 1'b0));
            chk("rx_valid", 32'(rx_valid), 32'(mRxValid));
            chk("rx_data", 32'(rx_data), 32'(mRxData));
`ifdef SHIFT_ENGINE_PARITY_EN
            chk("rx_parity", 32'(rx_parity), 32'(mParity));
`endif
        end
        sReset = reset; sShift = shift_en; sLsb = lsb_first;
        sValid = tx_valid; sSerial = serial_in; sData = tx_data;
    end

    // rx_valid pulse counter and last received word.
    int               rxPulses = 0;
    logic [WIDTH-1:0] rxLast = '0;
    always @(negedge clk) begin
        if (rx_valid) begin
            rxPulses++;
            rxLast = rx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadWord(input logic [WIDTH-1:0] d, input logic lsb);
        tx_data = d; lsb_first = lsb; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic strobe(input int gap);
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
        repeat (gap - 1) tick();
    endtask

    logic [WIDTH-1:0] seq;
    int               base;

    initial begin
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checkEn = 1'b1;
        chk("reset_tx_ready", 32'(tx_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        tick();

        // MSB-first 0xA5 looped back, strobes three cycles apart.
        loopback = 1'b1;
        base = rxPulses;
        loadWord(8'hA5, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            seq[WIDTH - 1 - i] = serial_out;
            strobe(3);
        end
        chk("msb_seq", 32'(seq), 32'h0000_00A5);
        chk("msb_pulses", 32'(rxPulses - base), 32'd1);
        chk("msb_rx", 32'(rxLast), 32'h0000_00A5);
`ifdef SHIFT_ENGINE_PARITY_EN
        chk("msb_parity", 32'(rx_parity), 32'd0);
`endif

        // LSB-first 0x01 with serial_in held high.
        loopback = 1'b0; serialDrv = 1'b1;
        base = rxPulses;
        loadWord(8'h01, 1'b1);
        for (int i = 0; i < WIDTH; i++) begin
            seq[WIDTH - 1 - i] = serial_out;
            strobe(1);
        end
        tick();
        chk("lsb_seq", 32'(seq), 32'h0000_0080);
        chk("lsb_pulses", 32'(rxPulses - base), 32'd1);
        chk("lsb_rx", 32'(rxLast), 32'h0000_00FF);
`ifdef SHIFT_ENGINE_PARITY_EN
        chk("lsb_parity", 32'(rx_parity), 32'd0);
`endif

        // Load coinciding with a strobe in IDLE: load only.
        loopback = 1'b1; serialDrv = 1'b0;
        base = rxPulses;
        tx_data = 8'h3C; lsb_first = 1'b0; tx_valid = 1'b1; shift_en = 1'b1;
        tick();
        tx_valid = 1'b0; shift_en = 1'b0;
        chk("coincide_cnt", 32'(dut.bitCounter.cnt), 32'd0);
        chk("coincide_busy", 32'(busy), 32'd1);
        for (int i = 0; i < WIDTH - 1; i++) strobe(2);
        chk("coincide_7_pulses", 32'(rxPulses - base), 32'd0);
        strobe(1);
        chk("coincide_8_valid", 32'(rx_valid), 32'd1);
        tick();
        chk("coincide_pulses", 32'(rxPulses - base), 32'd1);
        chk("coincide_rx", 32'(rxLast), 32'h0000_003C);

        // Reset after three strobes aborts the word.
        loadWord(8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) strobe(1);
        base = rxPulses;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tx_ready", 32'(tx_ready), 32'd1);
        chk("abort_rx_data", 32'(rx_data), 32'd0);
        for (int i = 0; i < 6; i++) strobe(2);
        chk("abort_pulses", 32'(rxPulses - base), 32'd0);

        // tx_valid held through a word; next word accepted after completion.
        base = rxPulses;
        tx_data = 8'h12; lsb_first = 1'b0; tx_valid = 1'b1;
        tick();
        tx_data = 8'hFF;
        for (int i = 0; i < WIDTH; i++) strobe(1);
        chk("held_valid", 32'(rx_valid), 32'd1);
        chk("held_rx", 32'(rx_data), 32'h0000_0012);
        chk("held_ready", 32'(tx_ready), 32'd1);
        tick();
        tx_valid = 1'b0;
        chk("held_accept_busy", 32'(busy), 32'd1);
        chk("held_accept_bit", 32'(serial_out), 32'd1);
        for (int i = 0; i < WIDTH; i++) strobe(1);
        tick();
        chk("held_pulses", 32'(rxPulses - base), 32'd2);
        chk("held_rx2", 32'(rxLast), 32'h0000_00FF);

        // Received word 0x07 (odd parity).
        base = rxPulses;
        loadWord(8'h07, 1'b0);
        for (int i = 0; i < WIDTH; i++) strobe(2);
        chk("odd_rx", 32'(rxLast), 32'h0000_0007);
        chk("odd_pulses", 32'(rxPulses - base), 32'd1);
`ifdef SHIFT_ENGINE_PARITY_EN
        chk("odd_parity", 32'(rx_parity), 32'd1);
`endif
        tick(); tick();

        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_engine

// File: doc/shift_engine.md
# shift_engine

Parametrised, framed serial shift engine, generalising the team's plain 8-bit shift register. It loads a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first or LSB-first on one-cycle shift strobes, capturing serial input in parallel. It counts bits, returns to idle after exactly WIDTH shifts, and presents the received word with a one-cycle valid pulse. It sits between a peripheral clock-edge generator (SPI-style master or slave front end) and the word-level controller.

## Interface
- WIDTH, 8, word length in bits; legal range is 2 or more.
- CNT_W, $clog2(WIDTH), localparam giving the bit-counter width.

- clk  in  1  single system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- shift_en  in  1  one-cycle strobe marking a peripheral clock edge; ignored in IDLE.
- lsb_first  in  1  bit order, sampled only at load; 1 means LSB first.
- tx_data  in  WIDTH  word to transmit.
- tx_valid  in  1  load request.
- tx_ready  out  1  high in IDLE; a load occurs when tx_valid and tx_ready are both high.
- serial_in  in  1  received bit, sampled on shift_en.
- serial_out  out  1  current transmit bit.
- rx_data  out  WIDTH  last completed received word; held until the next completion.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high in ACTIVE.
- rx_parity  out  1  XOR of rx_data; port exists only under SHIFT_ENGINE_PARITY_EN.

## Operation
- States: IDLE and ACTIVE. Internal registers: shreg[WIDTH], cnt[CNT_W], order_q.
- IDLE:
  - tx_ready=1, busy=0, serial_out=0.
  - On handshake: shreg←tx_data, order_q←lsb_first, cnt←0, go to ACTIVE.
  - shift_en is ignored.
- ACTIVE:
  - tx_ready=0 and busy=1. tx_valid is ignored and no data is latched.
  - serial_out = order_q ? shreg[0] : shreg[WIDTH-1].
- On shift_en in ACTIVE:
  - MSB-first: shreg←{shreg[WIDTH-2:0], serial_in}.
  - LSB-first: shreg←{serial_in, shreg[WIDTH-1:1]}.
  - cnt←cnt+1.
- Completion is the shift_en with cnt==WIDTH-1:
  - rx_data←the post-shift value.
  - rx_valid←1 for one cycle.
  - cnt←0 and go to IDLE.
  - cnt never wraps past WIDTH-1.
- If shift_en and a handshake coincide in IDLE, only the load happens. The word still needs WIDTH further strobes.
- Back-to-back words: no load in the completion cycle. The earliest next load is the cycle after completion, when tx_ready is back to 1.
- Reset, including mid-word:
  - state←IDLE.
  - shreg, cnt, order_q, rx_data and rx_valid all ←0.
  - No rx_valid is produced for the aborted word.

## Timing
- Reset values: tx_ready=1, busy=0, serial_out=0, rx_data=0, rx_valid=0, rx_parity=0.
- Handshake in cycle N: busy=1 and serial_out shows the first bit in cycle N+1.
- A shift_en in cycle M updates serial_out in cycle M+1.
- The k-th strobe (k=1..WIDTH) presents bit k+1 of the word. After the WIDTH-th strobe the output is 0 (IDLE).
- rx_valid is high in exactly one cycle: the cycle after the WIDTH-th strobe. busy=0 and tx_ready=1 in that same cycle.
- Minimum word time: WIDTH+1 cycles from handshake to the next tx_ready.

## Configuration
- SHIFT_ENGINE_PARITY_EN defined:
  - rx_parity is registered at completion together with rx_data and equals ^rx_data.
  - Reset value 0; held between completions.
- Undefined: the rx_parity port and its logic are absent. All other behaviour is identical.

## Structure
- Package shift_engine_pkg holds:
  - the state typedef (ST_IDLE, ST_ACTIVE);
  - the bit-order constants ORDER_MSB=0 and ORDER_LSB=1.
- One sub-module, shift_bit_counter:
  - parameter WIDTH; ports clk, reset, clear, inc;
  - outputs cnt and last (cnt==WIDTH-1).

## Test plan
- WIDTH=8, MSB-first, load 0xA5, serial_out looped to serial_in, 8 strobes 3 cycles apart:
  - serial_out sequence 1,0,1,0,0,1,0,1;
  - rx_data=0xA5 with a single-cycle rx_valid;
  - rx_parity=0 when the macro is on.
- LSB-first, load 0x01, serial_in=1, 8 strobes:
  - serial_out sequence 1,0,0,0,0,0,0,0;
  - rx_data=0xFF; rx_parity=0.
- tx_valid and shift_en together in IDLE with 0x3C:
  - load only, cnt=0;
  - rx_valid appears only after 8 more strobes;
  - a 7th strobe alone produces no rx_valid.
- Reset asserted after 3 strobes:
  - next cycle busy=0, tx_ready=1, rx_data=0;
  - no rx_valid pulse occurs afterwards.
- tx_valid held high with 0xFF during ACTIVE after loading 0x12:
  - 0xFF is ignored and rx reflects the 0x12 word;
  - 0xFF is accepted in the cycle after rx_valid.
- Parity build, received word 0x07: rx_parity=1.
